// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with a valid/ready handshake.
// The stages are unpack/classify, mantissa multiply, and normalise/round/pack. Subnormal inputs are flushed to zero.
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   product,
    output logic [4:0]             flags
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int EW2 = EXP_W + 2;
    localparam int PW  = 2 * MAN_W + 2;

    localparam logic signed [EXP_W+1:0] BIAS_C  = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EXP_W+1:0] EMAX_C  = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+1:0] EZERO_C = {EW2{1'b0}};
    localparam logic [W-1:0] QNAN_C = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Flag bit order: {invalid, overflow, underflow, inexact, special_in}
    localparam logic [4:0] F_NONE_C  = 5'b00000;
    localparam logic [4:0] F_SPEC_C  = 5'b00001;
    localparam logic [4:0] F_INV_C   = 5'b10001;
    localparam logic [4:0] F_OVF_C   = 5'b01010;
    localparam logic [4:0] F_UNF_C   = 5'b00110;

    logic                    stall_s;
    logic                    adv_s;

    logic                    sa_s;
    logic                    sb_s;
    logic [EXP_W-1:0]        ea_s;
    logic [EXP_W-1:0]        eb_s;
    logic [MAN_W-1:0]        ma_s;
    logic [MAN_W-1:0]        mb_s;
    logic                    a_zero_s;
    logic                    b_zero_s;
    logic                    a_inf_s;
    logic                    b_inf_s;
    logic                    a_nan_s;
    logic                    b_nan_s;
    logic                    sign_s;
    logic signed [EXP_W+1:0] exp_sum_s;
    logic                    spec_s;
    logic [W-1:0]            spec_word_s;
    logic [4:0]              spec_flags_s;

    logic                    v1_r;
    logic                    sign1_r;
    logic signed [EXP_W+1:0] exp1_r;
    logic [MAN_W-1:0]        ma1_r;
    logic [MAN_W-1:0]        mb1_r;
    logic                    spec1_r;
    logic [W-1:0]            spec_word1_r;
    logic [4:0]              spec_flags1_r;

    logic [PW-1:0]           prod_s;
    logic                    v2_r;
    logic                    sign2_r;
    logic signed [EXP_W+1:0] exp2_r;
    logic [PW-1:0]           prod2_r;
    logic                    spec2_r;
    logic [W-1:0]            spec_word2_r;
    logic [4:0]              spec_flags2_r;

    logic [PW-2:0]           norm_s;
    logic                    lost_s;
    logic signed [EXP_W+1:0] exp_n_s;
    logic [MAN_W:0]          mant_s;
    logic                    guard_s;
    logic                    round_s;
    logic                    sticky_s;
    logic                    round_up_s;
    logic [MAN_W+1:0]        rounded_s;
    logic                    carry_s;
    logic [MAN_W-1:0]        man_out_s;
    logic signed [EXP_W+1:0] exp_f_s;
    logic                    inexact_s;
    logic [W-1:0]            word_s;
    logic [4:0]              flags_s;

    logic                    v3_r;
    logic [W-1:0]            product_r;
    logic [4:0]              flags_r;

    assign stall_s   = v3_r & ~out_ready;
    assign adv_s     = ~stall_s;
    assign in_ready  = ~stall_s;
    assign out_valid = v3_r;
    assign product   = product_r;
    assign flags     = flags_r;

    assign sa_s      = a[W-1];
    assign sb_s      = b[W-1];
    assign ea_s      = a[W-2:MAN_W];
    assign eb_s      = b[W-2:MAN_W];
    assign ma_s      = a[MAN_W-1:0];
    assign mb_s      = b[MAN_W-1:0];
    assign a_zero_s  = (ea_s == {EXP_W{1'b0}});
    assign b_zero_s  = (eb_s == {EXP_W{1'b0}});
    assign a_inf_s   = (ea_s == {EXP_W{1'b1}}) && (ma_s == {MAN_W{1'b0}});
    assign b_inf_s   = (eb_s == {EXP_W{1'b1}}) && (mb_s == {MAN_W{1'b0}});
    assign a_nan_s   = (ea_s == {EXP_W{1'b1}}) && (ma_s != {MAN_W{1'b0}});
    assign b_nan_s   = (eb_s == {EXP_W{1'b1}}) && (mb_s != {MAN_W{1'b0}});
    assign sign_s    = sa_s ^ sb_s;
    assign exp_sum_s = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS_C;

    // S1 special-case classification; the decision rides down the pipe and overrides S3
    always_comb begin
        spec_s       = 1'b0;
        spec_word_s  = {W{1'b0}};
        spec_flags_s = F_NONE_C;
        if (a_nan_s || b_nan_s) begin
            spec_s       = 1'b1;
            spec_word_s  = QNAN_C;
            spec_flags_s = F_SPEC_C;
        end else if ((a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
            spec_s       = 1'b1;
            spec_word_s  = QNAN_C;
            spec_flags_s = F_INV_C;
        end else if (a_inf_s || b_inf_s) begin
            spec_s       = 1'b1;
            spec_word_s  = {sign_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flags_s = F_SPEC_C;
        end else if (a_zero_s || b_zero_s) begin
            spec_s       = 1'b1;
            spec_word_s  = {sign_s, {(W-1){1'b0}}};
            spec_flags_s = F_NONE_C;
        end else begin
            spec_s       = 1'b0;
            spec_word_s  = {W{1'b0}};
            spec_flags_s = F_NONE_C;
        end
    end

    // Stage 1 register: unpacked operands, exponent sum, special decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r          <= 1'b0;
            sign1_r       <= 1'b0;
            exp1_r        <= {EW2{1'b0}};
            ma1_r         <= {MAN_W{1'b0}};
            mb1_r         <= {MAN_W{1'b0}};
            spec1_r       <= 1'b0;
            spec_word1_r  <= {W{1'b0}};
            spec_flags1_r <= 5'b00000;
        end else if (adv_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                sign1_r       <= sign_s;
                exp1_r        <= exp_sum_s;
                ma1_r         <= ma_s;
                mb1_r         <= mb_s;
                spec1_r       <= spec_s;
                spec_word1_r  <= spec_word_s;
                spec_flags1_r <= spec_flags_s;
            end
        end
    end

    assign prod_s = PW'({1'b1, ma1_r}) * PW'({1'b1, mb1_r});

    // Stage 2 register: full-width mantissa product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r          <= 1'b0;
            sign2_r       <= 1'b0;
            exp2_r        <= {EW2{1'b0}};
            prod2_r       <= {PW{1'b0}};
            spec2_r       <= 1'b0;
            spec_word2_r  <= {W{1'b0}};
            spec_flags2_r <= 5'b00000;
        end else if (adv_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                sign2_r       <= sign1_r;
                exp2_r        <= exp1_r;
                prod2_r       <= prod_s;
                spec2_r       <= spec1_r;
                spec_word2_r  <= spec_word1_r;
                spec_flags2_r <= spec_flags1_r;
            end
        end
    end

    // The bit shifted out by normalisation still counts toward sticky
    assign norm_s     = prod2_r[PW-1] ? prod2_r[PW-1:1] : prod2_r[PW-2:0];
    assign lost_s     = prod2_r[PW-1] & prod2_r[0];
    assign exp_n_s    = exp2_r + {{(EXP_W+1){1'b0}}, prod2_r[PW-1]};
    assign mant_s     = norm_s[2*MAN_W:MAN_W];
    assign guard_s    = norm_s[MAN_W-1];
    assign round_s    = norm_s[MAN_W-2];
    assign sticky_s   = (|norm_s[MAN_W-3:0]) | lost_s;
    assign round_up_s = guard_s & (round_s | sticky_s | mant_s[0]);
    assign rounded_s  = {1'b0, mant_s} + {{(MAN_W+1){1'b0}}, round_up_s};
    assign carry_s    = rounded_s[MAN_W+1];
    assign man_out_s  = carry_s ? rounded_s[MAN_W:1] : rounded_s[MAN_W-1:0];
    assign exp_f_s    = exp_n_s + {{(EXP_W+1){1'b0}}, carry_s};
    assign inexact_s  = guard_s | round_s | sticky_s;

    // S3 range check and final result selection
    always_comb begin
        word_s  = {W{1'b0}};
        flags_s = F_NONE_C;
        if (spec2_r) begin
            word_s  = spec_word2_r;
            flags_s = spec_flags2_r;
        end else if (exp_f_s >= EMAX_C) begin
            word_s  = {sign2_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_s = F_OVF_C;
        end else if (exp_f_s <= EZERO_C) begin
            word_s  = {sign2_r, {(W-1){1'b0}}};
            flags_s = F_UNF_C;
        end else begin
            word_s  = {sign2_r, exp_f_s[EXP_W-1:0], man_out_s};
            flags_s = {3'b000, inexact_s, 1'b0};
        end
    end

    // Stage 3 register: packed product and flags drive the outputs directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_r      <= 1'b0;
            product_r <= {W{1'b0}};
            flags_r   <= 5'b00000;
        end else if (adv_s) begin
            v3_r <= v2_r;
            if (v2_r) begin
                product_r <= word_s;
                flags_r   <= flags_s;
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe: hand-computed binary32 vectors, latency, stall and reset sequences.
module tb_fp_mult_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic [4:0]  flags;

    int total;
    int bad;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [4:0]  f;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // Streams vectors 0..n-1; mode 0 keeps out_ready high, mode 1 uses the 1,0,0 pattern
    task automatic run_stream(input int n, input int mode);
        int in_idx = 0;
        int out_idx = 0;
        int cyc = 0;
        logic took_in = 1'b0;
        logic prev_stall = 1'b0;
        logic [31:0] prev_p = 32'h0;
        logic [4:0] prev_f = 5'h0;
        while (out_idx < n && cyc < 200) begin
            @(negedge clk);
            if (took_in) in_idx++;
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (in_idx < n) begin
                in_valid = 1'b1;
                a = vecs[in_idx].a;
                b = vecs[in_idx].b;
            end else begin
                in_valid = 1'b0;
                a = 32'h0;
                b = 32'h0;
            end
            #1;
            chk("in_ready_vs_stall", {31'h0, in_ready}, {31'h0, !(out_valid && !out_ready)});
            if (prev_stall) begin
                chk("held_product", product, prev_p);
                chk("held_flags", {27'h0, flags}, {27'h0, prev_f});
            end
            if (out_valid && out_ready) begin
                chk($sformatf("vec%0d_product", out_idx), product, vecs[out_idx].p);
                chk($sformatf("vec%0d_flags", out_idx), {27'h0, flags}, {27'h0, vecs[out_idx].f});
                out_idx++;
            end
            took_in = in_valid && in_ready;
            prev_stall = out_valid && !out_ready;
            prev_p = product;
            prev_f = flags;
            cyc++;
        end
        chk("stream_timeout_count", out_idx, n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("no_extra_output", {31'h0, out_valid}, 32'h0);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000};
        vecs[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00010};
        vecs[2]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 5'b01010};
        vecs[3]  = '{32'h00800000, 32'h00800000, 32'h00000000, 5'b00110};
        vecs[4]  = '{32'h7F800000, 32'h80000000, 32'h7FC00000, 5'b10001};
        vecs[5]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b00001};
        vecs[6]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00001};
        vecs[7]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 5'b00000};
        vecs[8]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000};
        vecs[9]  = '{32'hC0400000, 32'h40400000, 32'hC1100000, 5'b00000};
        vecs[10] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 5'b00010};
        vecs[11] = '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 5'b00010};
        vecs[12] = '{32'h7F800000, 32'h7F800000, 32'h7F800000, 5'b00001};
        vecs[13] = '{32'h00000000, 32'h80000000, 32'h80000000, 5'b00000};
        vecs[14] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 5'b00010};
        vecs[15] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 5'b00010};
        vecs[16] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 5'b00000};
        vecs[17] = '{32'h00800000, 32'h3F800000, 32'h00800000, 5'b00000};
        vecs[18] = '{32'h00800000, 32'h3F000000, 32'h00000000, 5'b00110};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = 32'h0;
        b = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_product", product, 32'h0);
        chk("reset_flags", {27'h0, flags}, 32'h0);
        chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
        rst_n = 1'b1;

        // Single operation: out_valid rises after exactly three rising edges
        in_valid = 1'b1;
        a = vecs[0].a;
        b = vecs[0].b;
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_edge1", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        chk("lat_edge2", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        chk("lat_edge3", {31'h0, out_valid}, 32'h1);
        chk("lat_product", product, 32'h40400000);
        chk("lat_flags", {27'h0, flags}, 32'h0);
        @(negedge clk);
        chk("lat_drop", {31'h0, out_valid}, 32'h0);

        run_stream(NV, 0);
        run_stream(8, 1);

        // Reset with three operations in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = vecs[9 + i].a;
            b = vecs[9 + i].b;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("pre_reset_valid", {31'h0, out_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_reset_in_ready", {31'h0, in_ready}, 32'h1);
        chk("mid_reset_product", product, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_reset_quiet", {31'h0, out_valid}, 32'h0);
        end
        in_valid = 1'b1;
        a = vecs[14].a;
        b = vecs[14].b;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_valid", {31'h0, out_valid}, 32'h1);
        chk("post_reset_product", product, vecs[14].p);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_mult_pipe.md
FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

Interface
REQ-001 The module SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 The module SHALL have parameter MAN_W, default 23, meaning stored mantissa width; word width W = 1+EXP_W+MAN_W.
REQ-003 The module SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 The module SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The module SHALL have port in_valid  input  1  operand pair a/b valid this cycle.
REQ-006 The module SHALL have port in_ready  output  1  pipeline accepts operands this cycle.
REQ-007 The module SHALL have ports a, b  input  W  IEEE-style operands: sign, biased exponent, mantissa.
REQ-008 The module SHALL have port out_valid  output  1  product/flags valid.
REQ-009 The module SHALL have port out_ready  input  1  consumer accepts product this cycle.
REQ-010 The module SHALL have port product  output  W  rounded result.
REQ-011 The module SHALL have port flags  output  5  {invalid, overflow, underflow, inexact, special_in}, qualified by out_valid.

Function
REQ-012 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-013 Three-stage pipeline (S1 unpack/classify/exponent sum, S2 mantissa multiply, S3 normalise/round/pack); latency exactly 3 cycles from transfer in to out_valid when unstalled.
REQ-014 Stall = out_valid && !out_ready; on stall every stage holds its contents; in_ready = !stall.
REQ-015 Throughput one operation per cycle when out_ready held high; bubbles propagate as invalid stage slots.
REQ-016 Biased exponent sum computed at EXP_W+2 bits signed: e = ea + eb - BIAS, BIAS = 2^(EXP_W-1)-1.
REQ-017 Mantissa product (MAN_W+1)x(MAN_W+1) -> 2*MAN_W+2 bits with hidden 1; if MSB set, shift right 1 and e+1.
REQ-018 Rounding round-to-nearest-even using guard, round, sticky bits; mantissa carry-out after rounding renormalises and increments e.
REQ-019 inexact SHALL be 1 when any discarded bit is non-zero.
REQ-020 e >= 2^EXP_W-1 after rounding: product = signed infinity, overflow=1, inexact=1.
REQ-021 e <= 0: product = signed zero (flush), underflow=1, inexact=1 unless exact zero operands.
REQ-022 Subnormal inputs (exp 0, mantissa non-zero) treated as signed zero.
REQ-023 Either operand NaN: product = canonical quiet NaN {0, all-ones exp, 1, zeros}, special_in=1.
REQ-024 Infinity x zero: canonical quiet NaN, invalid=1, special_in=1.
REQ-025 Infinity x finite non-zero or infinity: signed infinity (sign = sa^sb), special_in=1, no overflow.
REQ-026 Zero x finite: signed zero, all flags 0 except none; sign = sa^sb.
REQ-027 Special-case decision made in S1 and carried down the pipe; S3 overrides arithmetic result with it.
REQ-028 product and flags SHALL be stable while out_valid && !out_ready.

Reset
REQ-029 rst_n low asynchronously clears all stage valid bits; out_valid=0, product=0, flags=0, in_ready=1 while in reset.
REQ-030 Reset mid-operation discards all in-flight operations; none emerge after rst_n release.
REQ-031 First transfer in allowed on first rising edge after rst_n deasserts.

Verification
REQ-032 a=0x3FC00000, b=0x40000000, out_ready=1 -> 3 cycles later product=0x40400000, flags=0.
REQ-033 a=b=0x3F800001 -> product=0x3F800002, inexact=1 only (RNE of 1+2^-22+2^-46).
REQ-034 a=b=0x7F000000 -> product=0x7F800000, overflow=1, inexact=1; a=b=0x00800000 -> product=0x00000000, underflow=1, inexact=1.
REQ-035 a=0x7F800000, b=0x80000000 -> product=0x7FC00000, invalid=1, special_in=1; a=0x7FC00001, b=0x3F800000 -> 0x7FC00000, special_in=1.
REQ-036 Back-to-back 8 operations with out_ready toggling 1,0,0,1,... -> in_ready=0 exactly when out_valid && !out_ready, all 8 results in order, none lost or duplicated, product held stable during stall.
REQ-037 Reset asserted with 3 operations in flight -> out_valid=0 immediately, stays 0 after release until new input, in_ready=1.
